// File: rtl/x_sweep_ctrl.sv
// Exhaustive sweep sequencer for the 3-input block x: steps {A,B,C} through 0..7,
// captures F per vector and scores the captured truth table against an expected pattern.
module x_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] expected,
  output logic       A,
  output logic       B,
  output logic       C,
  input  logic       F,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       mismatch,
  output logic [2:0] err_idx,
  output logic [3:0] err_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  // With no settle time each vector is sampled in the cycle it is first driven.
  localparam state_t VEC_ST = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] abc_q, abc_d;
  logic [7:0] exp_q, exp_d;
  logic [7:0] table_q, table_d;
  logic [3:0] err_count_q, err_count_d;
  logic [2:0] err_idx_q, err_idx_d;
  logic       mismatch_q, mismatch_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Next-state, vector drive and scoring logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    abc_d       = abc_q;
    exp_d       = exp_q;
    table_d     = table_q;
    err_count_d = err_count_q;
    err_idx_d   = err_idx_q;
    mismatch_d  = mismatch_q;

    case (state_q)
      ST_IDLE: begin
        abc_d = 3'd0;
        if (start) begin
          exp_d       = expected;
          table_d     = 8'h00;
          err_count_d = 4'd0;
          err_idx_d   = 3'd0;
          mismatch_d  = 1'b0;
          idx_d       = 3'd0;
          cnt_d       = SETTLE_LD;
          state_d     = VEC_ST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        table_d[idx_q] = F;
        if (F != exp_q[idx_q]) begin
          err_count_d = err_count_q + 4'd1;
          mismatch_d  = 1'b1;
          // Only the first failing index is reported.
          if (err_count_q == 4'd0) begin
            err_idx_d = idx_q;
          end else begin
            err_idx_d = err_idx_q;
          end
        end else begin
          err_count_d = err_count_q;
        end
        if (idx_q == 3'd7) begin
          abc_d   = 3'd0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          abc_d   = idx_q + 3'd1;
          cnt_d   = SETTLE_LD;
          state_d = VEC_ST;
        end
      end
      ST_DONE: begin
        abc_d   = 3'd0;
        state_d = ST_IDLE;
      end
      default: begin
        abc_d   = 3'd0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= 3'd0;
      abc_q       <= 3'd0;
      exp_q       <= 8'h00;
      table_q     <= 8'h00;
      err_count_q <= 4'd0;
      err_idx_q   <= 3'd0;
      mismatch_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      abc_q       <= abc_d;
      exp_q       <= exp_d;
      table_q     <= table_d;
      err_count_q <= err_count_d;
      err_idx_q   <= err_idx_d;
      mismatch_q  <= mismatch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign A         = abc_q[2];
  assign B         = abc_q[1];
  assign C         = abc_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign mismatch  = mismatch_q;
  assign err_idx   = err_idx_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_x_sweep_ctrl.sv
// Directed bench for x_sweep_ctrl: default-settle instance driven by F=(A&B)|C and a
// zero-settle instance driven by F=A^B^C, both modelled in the bench.
module tb_x_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  int         total = 0;
  int         bad = 0;

  // default-settle instance
  logic       start0;
  logic [7:0] expected0;
  logic       a0, b0, c0, f0, busy0, done0, mismatch0;
  logic [7:0] table0;
  logic [2:0] err_idx0;
  logic [3:0] err_count0;
  logic       f_force, f_rand;

  // zero-settle instance
  logic       start1;
  logic [7:0] expected1;
  logic       a1, b1, c1, f1, busy1, done1, mismatch1;
  logic [7:0] table1;
  logic [2:0] err_idx1;
  logic [3:0] err_count1;

  always #5 clk = ~clk;

  assign f0 = f_force ? f_rand : ((a0 & b0) | c0);
  assign f1 = f_force ? f_rand : (a1 ^ b1 ^ c1);

  x_sweep_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .expected(expected0),
    .A(a0), .B(b0), .C(c0), .F(f0), .busy(busy0), .done(done0),
    .table_out(table0), .mismatch(mismatch0), .err_idx(err_idx0), .err_count(err_count0)
  );

  x_sweep_ctrl #(.SETTLE_CYCLES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected1),
    .A(a1), .B(b1), .C(c1), .F(f1), .busy(busy1), .done(done1),
    .table_out(table1), .mismatch(mismatch1), .err_idx(err_idx1), .err_count(err_count1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Start a run on u_dut0 and observe ncyc cycles after the accept edge.
  task automatic run0(input logic [7:0] exp, input bit hold, input int pa, input int pb,
                      input int ncyc, output int done_at1, output int done_at2,
                      output int done_cnt, output int busy_cnt, output int abc_err);
    done_at1 = 0; done_at2 = 0; done_cnt = 0; busy_cnt = 0; abc_err = 0;
    expected0 = exp;
    start0 = 1'b1;
    tick();
    for (int k = 1; k <= ncyc; k++) begin
      if (done0) begin
        done_cnt++;
        if (done_at1 == 0) done_at1 = k;
        else if (done_at2 == 0) done_at2 = k;
      end
      if (busy0) busy_cnt++;
      if (k <= 24 && {a0, b0, c0} !== 3'((k - 1) / 3)) abc_err++;
      if (k == 25 && {a0, b0, c0} !== 3'd0) abc_err++;
      start0 = hold || (k == pa) || (k == pb);
      tick();
    end
    start0 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    f_force = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start0 = 1'($urandom); start1 = 1'($urandom); f_rand = 1'($urandom);
      tick();
    end
    total++;
    if ({busy0, done0, a0, b0, c0, table0, mismatch0, err_idx0, err_count0} !== 21'd0) begin
      bad++;
      $display("FAIL reset_dut0: got %0h want 0",
               {busy0, done0, a0, b0, c0, table0, mismatch0, err_idx0, err_count0});
    end
    total++;
    if ({busy1, done1, a1, b1, c1, table1, mismatch1, err_idx1, err_count1} !== 21'd0) begin
      bad++;
      $display("FAIL reset_dut1: got %0h want 0",
               {busy1, done1, a1, b1, c1, table1, mismatch1, err_idx1, err_count1});
    end
    start0 = 1'b0; start1 = 1'b0; f_force = 1'b0; rst_n = 1'b1;
    idle_cycles(3);
    total++;
    if ({busy0, done0, a0, b0, c0, table0, mismatch0, err_idx0, err_count0} !== 21'd0) begin
      bad++;
      $display("FAIL reset_release: got %0h want 0",
               {busy0, done0, a0, b0, c0, table0, mismatch0, err_idx0, err_count0});
    end
  endtask

  task automatic test_clean_pass();
    int d1, d2, dc, bc, ae;
    run0(8'hEA, 1'b0, 0, 0, 30, d1, d2, dc, bc, ae);
    total++;
    if (bc !== 24) begin bad++; $display("FAIL clean_busy_cycles: got %0d want 24", bc); end
    total++;
    if (d1 !== 25) begin bad++; $display("FAIL clean_done_cycle: got %0d want 25", d1); end
    total++;
    if (dc !== 1) begin bad++; $display("FAIL clean_done_count: got %0d want 1", dc); end
    total++;
    if (ae !== 0) begin bad++; $display("FAIL clean_abc_sequence: got %0d wrong cycles want 0", ae); end
    total++;
    if (table0 !== 8'hEA) begin bad++; $display("FAIL clean_table: got %0h want ea", table0); end
    total++;
    if ({mismatch0, err_count0, err_idx0} !== 8'd0) begin
      bad++;
      $display("FAIL clean_errors: got mm=%0d cnt=%0d idx=%0d want 0/0/0",
               mismatch0, err_count0, err_idx0);
    end
  endtask

  task automatic test_mismatch();
    int d1, d2, dc, bc, ae;
    run0(8'h6A, 1'b0, 0, 0, 30, d1, d2, dc, bc, ae);
    total++;
    if ({mismatch0, err_count0, err_idx0} !== {1'b1, 4'd1, 3'd7}) begin
      bad++;
      $display("FAIL single_mismatch: got mm=%0d cnt=%0d idx=%0d want 1/1/7",
               mismatch0, err_count0, err_idx0);
    end
    run0(8'h15, 1'b0, 0, 0, 30, d1, d2, dc, bc, ae);
    total++;
    if ({mismatch0, err_count0, err_idx0} !== {1'b1, 4'd8, 3'd0}) begin
      bad++;
      $display("FAIL total_mismatch: got mm=%0d cnt=%0d idx=%0d want 1/8/0",
               mismatch0, err_count0, err_idx0);
    end
    total++;
    if (table0 !== 8'hEA) begin bad++; $display("FAIL total_mismatch_table: got %0h want ea", table0); end
  endtask

  task automatic test_start_handling();
    int d1, d2, dc, bc, ae;
    run0(8'hEA, 1'b0, 3, 20, 40, d1, d2, dc, bc, ae);
    total++;
    if (dc !== 1 || d1 !== 25) begin
      bad++;
      $display("FAIL ignored_start: got done_cnt=%0d at %0d want 1 at 25", dc, d1);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, dc, bc, ae;
    run0(8'hEA, 1'b1, 0, 0, 60, d1, d2, dc, bc, ae);
    total++;
    if (d1 !== 25 || d2 !== 51) begin
      bad++;
      $display("FAIL back_to_back: got done at %0d,%0d want 25,51", d1, d2);
    end
    idle_cycles(30);
    total++;
    if (table0 !== 8'hEA || busy0 !== 1'b0) begin
      bad++;
      $display("FAIL back_to_back_end: got table=%0h busy=%0d want ea/0", table0, busy0);
    end
  endtask

  task automatic test_reset_mid_run();
    int d1, d2, dc, bc, ae;
    int late_done;
    late_done = 0;
    expected0 = 8'hEA;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    idle_cycles(9);
    rst_n = 1'b0;
    tick();
    total++;
    if ({busy0, done0, a0, b0, c0, table0, mismatch0, err_idx0, err_count0} !== 21'd0) begin
      bad++;
      $display("FAIL mid_run_reset: got %0h want 0",
               {busy0, done0, a0, b0, c0, table0, mismatch0, err_idx0, err_count0});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (done0 || busy0) late_done++;
      tick();
    end
    total++;
    if (late_done !== 0) begin bad++; $display("FAIL mid_run_no_done: got %0d active cycles want 0", late_done); end
    run0(8'hEA, 1'b0, 0, 0, 30, d1, d2, dc, bc, ae);
    total++;
    if (d1 !== 25 || table0 !== 8'hEA) begin
      bad++;
      $display("FAIL after_reset_run: got done=%0d table=%0h want 25/ea", d1, table0);
    end
  endtask

  task automatic test_zero_settle();
    int done_at, abc_err, busy_cnt;
    done_at = 0; abc_err = 0; busy_cnt = 0;
    expected1 = 8'h96;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (done1 && done_at == 0) done_at = k;
      if (busy1) busy_cnt++;
      if (k <= 8 && {a1, b1, c1} !== 3'(k - 1)) abc_err++;
      tick();
    end
    total++;
    if (done_at !== 9 || busy_cnt !== 8) begin
      bad++;
      $display("FAIL zero_settle_timing: got done=%0d busy=%0d want 9/8", done_at, busy_cnt);
    end
    total++;
    if (abc_err !== 0) begin bad++; $display("FAIL zero_settle_abc: got %0d wrong cycles want 0", abc_err); end
    total++;
    if (table1 !== 8'h96 || mismatch1 !== 1'b0 || err_count1 !== 4'd0) begin
      bad++;
      $display("FAIL zero_settle_result: got table=%0h mm=%0d cnt=%0d want 96/0/0",
               table1, mismatch1, err_count1);
    end
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    expected0 = 8'h00; expected1 = 8'h00;
    f_force = 1'b0; f_rand = 1'b0;
    test_reset();
    test_clean_pass();
    test_mismatch();
    test_start_handling();
    test_back_to_back();
    test_reset_mid_run();
    test_zero_settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
